// File: rtl/execute_unit_mc.sv
// Multi-cycle MIPS execute stage: start/busy/done handshake, registered ALU results,
// iterative unsigned multiply/divide into HI/LO with mfhi/mflo readback.
module execute_unit_mc #(
    parameter int WIDTH    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] sign_extended,
    input  logic [WIDTH-1:0] pc_next,
    input  logic [1:0]       alu_op,
    input  logic             alu_src,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_branch,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                           F_NOR = 6'h27, F_SLT = 6'h2A, F_MULTU = 6'h19, F_DIVU = 6'h1B,
                           F_MFHI = 6'h10, F_MFLO = 6'h12;

    typedef enum logic [2:0] {IDLE, CALC, MUL, DIV, FIN} state_t;
    state_t state, state_d;

    logic [WIDTH-1:0]        op1_p0, op2_p0;
    logic [1:0]              alu_op_p0;
    logic [5:0]              funct_p0;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        work_hi, work_lo;
    logic [WIDTH-1:0]        calc_res;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          div_trial;
    logic [WIDTH-1:0]        div_diff;
    logic                    div_ge;
    logic                    iter_last;
    logic signed [WIDTH-1:0] op1_s, op2_s;

    assign op1_s     = op1_p0;
    assign op2_s     = op2_p0;
    assign iter_last = (cnt == CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        busy    = (state != IDLE);
        done    = (state == FIN);
        case (state)
            IDLE: if (start) begin
                if (alu_op == 2'b10 && sign_extended[5:0] == F_MULTU)     state_d = MUL;
                else if (alu_op == 2'b10 && sign_extended[5:0] == F_DIVU) state_d = DIV;
                else                                                      state_d = CALC;
            end
            CALC:    state_d = FIN;
            MUL,
            DIV:     if (iter_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        calc_res = '0;
        case (alu_op_p0)
            2'b00: calc_res = op1_p0 + op2_p0;
            2'b01: calc_res = op1_p0 - op2_p0;
            2'b10: case (funct_p0)
                F_ADD:   calc_res = op1_p0 + op2_p0;
                F_SUB:   calc_res = op1_p0 - op2_p0;
                F_AND:   calc_res = op1_p0 & op2_p0;
                F_OR:    calc_res = op1_p0 | op2_p0;
                F_NOR:   calc_res = ~(op1_p0 | op2_p0);
                F_SLT:   calc_res = (op1_s < op2_s) ? WIDTH'(1) : '0;
                F_MFHI:  calc_res = hi;
                F_MFLO:  calc_res = lo;
                default: calc_res = '0;
            endcase
            default: calc_res = '0;
        endcase
    end

    // Shift-add multiply: work_lo holds the multiplier and shifts out as product bits arrive.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op2_p0} : '0);
    // Restoring divide: work_hi is the partial remainder, work_lo dividend/quotient.
    assign div_trial = {work_hi, work_lo[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, op2_p0});
    assign div_diff  = div_trial[WIDTH-1:0] - op2_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            op1_p0      <= '0;
            op2_p0      <= '0;
            alu_op_p0   <= '0;
            funct_p0    <= '0;
            cnt         <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            alu_result  <= '0;
            zero        <= 1'b0;
            pc_branch   <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op1_p0      <= data1;
                    op2_p0      <= alu_src ? sign_extended : data2;
                    alu_op_p0   <= alu_op;
                    funct_p0    <= sign_extended[5:0];
                    pc_branch   <= pc_next + (sign_extended << BR_SHIFT);
                    div_by_zero <= 1'b0;
                    cnt         <= '0;
                    work_hi     <= '0;
                    work_lo     <= data1;
                end
                CALC: begin
                    alu_result <= calc_res;
                    zero       <= (calc_res == '0);
                end
                MUL: begin
                    if (iter_last) begin
                        hi         <= work_hi;
                        lo         <= work_lo;
                        alu_result <= work_lo;
                        zero       <= (work_lo == '0);
                    end else begin
                        work_hi <= mul_sum[WIDTH:1];
                        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                        cnt     <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (iter_last) begin
                        if (op2_p0 == '0) begin
                            hi          <= op1_p0;
                            lo          <= '1;
                            alu_result  <= '1;
                            zero        <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi         <= work_hi;
                            lo         <= work_lo;
                            alu_result <= work_lo;
                            zero       <= (work_lo == '0);
                        end
                    end else begin
                        work_hi <= div_ge ? div_diff : div_trial[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], div_ge};
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit_mc.sv
// Directed bench for execute_unit_mc: vector table of single-cycle ops plus
// hand-written multiply/divide, mid-op start and mid-op reset sequences.
module tb_execute_unit_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, alu_src, busy, done, zero, div_by_zero;
    logic [W-1:0] data1, data2, sign_extended, pc_next, alu_result, pc_branch, hi, lo;
    logic [1:0]   alu_op;

    int n_cmp = 0, n_fail = 0, ecount = 0, t0 = 0, lat = 0;

    execute_unit_mc #(.WIDTH(W), .BR_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .data1(data1), .data2(data2),
        .sign_extended(sign_extended), .pc_next(pc_next), .alu_op(alu_op),
        .alu_src(alu_src), .busy(busy), .done(done), .alu_result(alu_result),
        .zero(zero), .pc_branch(pc_branch), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct packed {
        logic [1:0]   op;
        logic         src;
        logic [W-1:0] d1, d2, se, pc, res, pcb;
        logic         z;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request and return #1 after the start edge.
    task automatic start_op(input logic [1:0] op, input logic src, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] se, input logic [W-1:0] pc);
        @(negedge clk);
        alu_op = op; alu_src = src; data1 = d1; data2 = d2; sign_extended = se; pc_next = pc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = ecount;
    endtask

    // Latency in edges from the start edge to the edge that samples done.
    task automatic wait_done(output int l);
        int guard = 0;
        while (!done && guard < 200) begin
            @(posedge clk);
            #1 guard++;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
        l = ecount - t0 + 1;
    endtask

    task automatic finish_op;
        @(posedge clk);
        #1;
        check("idle_busy", W'(busy), '0);
        check("idle_done", W'(done), '0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic src, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] se, input logic [W-1:0] pc);
        start_op(op, src, d1, d2, se, pc);
        wait_done(lat);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; alu_op = '0; alu_src = 1'b0;
        data1 = '0; data2 = '0; sign_extended = '0; pc_next = '0;

        //          op     src   d1            d2            se            pc     res           pcb           z
        tbl[0]  = '{2'b00, 1'b1, 32'h10,       32'h0,        32'h4,        32'h0, 32'h14,       32'h10,       1'b0};
        tbl[1]  = '{2'b01, 1'b0, 32'h1234,     32'h1234,     32'hFFFFFFFE, 32'h40,32'h0,        32'h38,       1'b1};
        tbl[2]  = '{2'b10, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h2A,       32'h0, 32'h1,        32'hA8,       1'b0};
        tbl[3]  = '{2'b10, 1'b0, 32'h0,        32'h0,        32'h27,       32'h0, 32'hFFFFFFFF, 32'h9C,       1'b0};
        tbl[4]  = '{2'b10, 1'b0, 32'hF0F0,     32'hFF00,     32'h24,       32'h0, 32'hF000,     32'h90,       1'b0};
        tbl[5]  = '{2'b10, 1'b0, 32'hF0F0,     32'h0F0F,     32'h25,       32'h0, 32'hFFFF,     32'h94,       1'b0};
        tbl[6]  = '{2'b10, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h20,       32'h0, 32'h0,        32'h80,       1'b1};
        tbl[7]  = '{2'b10, 1'b0, 32'h3,        32'h5,        32'h22,       32'h0, 32'hFFFFFFFE, 32'h88,       1'b0};
        tbl[8]  = '{2'b10, 1'b0, 32'h1,        32'hFFFFFFFF, 32'h2A,       32'h0, 32'h0,        32'hA8,       1'b1};
        tbl[9]  = '{2'b10, 1'b0, 32'h5,        32'h6,        32'h3F,       32'h0, 32'h0,        32'hFC,       1'b1};
        tbl[10] = '{2'b11, 1'b0, 32'h5,        32'h6,        32'h0,        32'h4, 32'h0,        32'h4,        1'b1};
        tbl[11] = '{2'b10, 1'b0, 32'h7,        32'h9,        32'h12,       32'h0, 32'h0,        32'h48,       1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_result", alu_result, '0);
        check("rst_pcb", pc_branch, '0);
        check("rst_hilo", hi | lo, '0);
        check("rst_dbz", W'(div_by_zero), '0);
        rst = 1'b0;

        // add immediate: busy for exactly two cycles, done on the second edge
        start_op(2'b00, 1'b1, 32'h10, 32'h0, 32'h4, 32'h0);
        check("add_busy_c0", W'({busy, done}), W'(2'b10));
        @(posedge clk); #1;
        check("add_busy_c1", W'({busy, done}), W'(2'b11));
        check("add_result", alu_result, 32'h14);
        @(posedge clk); #1;
        check("add_busy_c2", W'({busy, done}), W'(2'b00));

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].src, tbl[i].d1, tbl[i].d2, tbl[i].se, tbl[i].pc);
            check($sformatf("vec%0d_lat", i), W'(lat), W'(2));
            check($sformatf("vec%0d_result", i), alu_result, tbl[i].res);
            check($sformatf("vec%0d_zero", i), W'(zero), W'(tbl[i].z));
            check($sformatf("vec%0d_pcb", i), pc_branch, tbl[i].pcb);
            finish_op();
        end

        // multu with an ignored start in the middle
        start_op(2'b10, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h19, 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        alu_op = 2'b00; data1 = 32'h55; data2 = 32'h1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat);
        check("mul_lat", W'(lat), W'(W + 2));
        check("mul_hi", hi, 32'h1);
        check("mul_lo", lo, 32'hFFFFFFFE);
        check("mul_result", alu_result, 32'hFFFFFFFE);
        check("mul_pcb", pc_branch, 32'h64);
        finish_op();
        run_op(2'b10, 1'b0, 32'h0, 32'h0, 32'h10, 32'h0);
        check("mfhi", alu_result, 32'h1);
        finish_op();
        run_op(2'b10, 1'b0, 32'h0, 32'h0, 32'h12, 32'h0);
        check("mflo", alu_result, 32'hFFFFFFFE);
        finish_op();

        run_op(2'b10, 1'b0, 32'd100, 32'd7, 32'h1B, 32'h0);
        check("div_lat", W'(lat), W'(W + 2));
        check("div_lo", lo, 32'd14);
        check("div_hi", hi, 32'd2);
        check("div_dbz", W'(div_by_zero), '0);
        finish_op();
        run_op(2'b10, 1'b0, 32'd5, 32'd0, 32'h1B, 32'h0);
        check("div0_lat", W'(lat), W'(W + 2));
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'd5);
        check("div0_dbz", W'(div_by_zero), W'(1));
        finish_op();
        run_op(2'b00, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0);
        check("dbz_cleared", W'(div_by_zero), '0);
        check("hilo_hold", hi, 32'd5);
        finish_op();

        // reset in the middle of a multu
        start_op(2'b10, 1'b0, 32'h1234, 32'h10, 32'h19, 32'h0);
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_busy", W'(busy), '0);
        check("abort_hilo", hi | lo, '0);
        check("abort_result", alu_result, '0);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", W'(dones), '0);
        run_op(2'b00, 1'b0, 32'd20, 32'd22, 32'h0, 32'h0);
        check("after_abort_lat", W'(lat), W'(2));
        check("after_abort_result", alu_result, 32'd42);
        finish_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
